// File: rtl/dft_piso_scanout.sv
// dft_piso_scanout: scan-load serialiser for the DFT datapath.
// Host words are buffered in a DEPTH-entry FIFO. Each accepted op shifts exactly
// CHAIN_LEN bits onto the scan chain, and then pulses op_commit.
// Build option: define DFT_PISO_MSB_FIRST_EN to shift each word MSB first.
// The default build shifts LSB first.
module dft_piso_scanout #(
    parameter int WORD_W    = 32,
    parameter int DEPTH     = 8,
    parameter int CHAIN_LEN = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WORD_W-1:0]        din,
    input  logic                     din_val,
    output logic                     din_rdy,
    input  logic                     op,
    output logic                     op_ack,
    output logic                     op_commit,
    output logic                     scaning,
    output logic                     sc_sen,
    output logic                     dft_sout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = $clog2(WORD_W) + 1;
    localparam int TOT_W = $clog2(CHAIN_LEN) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [1:0]        state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_next;
    logic [REM_W-1:0]  rem;
    logic [TOT_W-1:0]  tot;
    logic              out_bit;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // din_rdy comes from the registered count.
    // A pop while the FIFO is full does not open a slot until the next cycle.
    assign fifo_empty = (count == '0);
    assign din_rdy    = (count != CNT_W'(DEPTH));
    assign push       = din_val && din_rdy;

`ifdef DFT_PISO_MSB_FIRST_EN
    assign shreg_next = {shreg[WORD_W-2:0], 1'b0};
    assign out_bit    = shreg[WORD_W-1];
`else
    assign shreg_next = {1'b0, shreg[WORD_W-1:1]};
    assign out_bit    = shreg[0];
`endif

    // Pop request: the first word in LOAD, or a seamless reload when a word runs out mid-op.
    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        pop = 1'b0;
        case (state)
            ST_LOAD:  pop = !fifo_empty;
            ST_SHIFT: pop = (tot != TOT_W'(1)) && (rem == REM_W'(1)) && !fifo_empty;
            default:  pop = 1'b0;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; a flush only clears pointers and count, and stale words are never read.
        if (push) mem[wr_ptr] <= din;
    end

    // Op sequencing: accept, load the first word, shift CHAIN_LEN bits with reloads, then commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            rem    <= '0;
            tot    <= '0;
            op_ack <= 1'b0;
        end else begin
            op_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op) begin
                        state  <= ST_LOAD;
                        tot    <= TOT_W'(CHAIN_LEN);
                        op_ack <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        rem   <= REM_W'(WORD_W);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    tot   <= tot - 1'b1;
                    shreg <= shreg_next;
                    rem   <= rem - 1'b1;
                    if (tot == TOT_W'(1)) begin
                        state <= ST_DONE;
                    end else if (rem == REM_W'(1)) begin
                        if (pop) begin
                            shreg <= mem[rd_ptr];
                            rem   <= REM_W'(WORD_W);
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and scan outputs decode the registered state only.
    assign op_commit = (state == ST_DONE);
    assign scaning   = (state == ST_LOAD) || (state == ST_SHIFT);
    assign sc_sen    = (state == ST_SHIFT);
    assign dft_sout  = sc_sen & out_bit;

endmodule

// File: tb/tb_dft_piso_scanout.sv
// tb_dft_piso_scanout: queue-based reference model compared every cycle, plus directed literal checks.
// The bench honours DFT_PISO_MSB_FIRST_EN the same way as the design.
`timescale 1ns/1ps
module tb_dft_piso_scanout;
    localparam int W   = 32;
    localparam int D   = 8;
    localparam int CL  = 256;
    localparam int CL2 = 40;
    localparam int CW  = $clog2(D) + 1;

    logic          clk;
    logic          reset;
    logic [W-1:0]  din;
    logic          din_val;
    logic          op;
    logic          din_rdy, op_ack, op_commit, scaning, sc_sen, dft_sout;
    logic [CW-1:0] count;

    logic [W-1:0]  din2;
    logic          din_val2;
    logic          op2;
    logic          din_rdy2, op_ack2, op_commit2, scaning2, sc_sen2, dft_sout2;
    logic [CW-1:0] count2;

    int n_vec  = 0;
    int n_miss = 0;
    bit armed  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dft_piso_scanout #(.WORD_W(W), .DEPTH(D), .CHAIN_LEN(CL)) dut (
        .clk(clk), .reset(reset), .din(din), .din_val(din_val), .din_rdy(din_rdy),
        .op(op), .op_ack(op_ack), .op_commit(op_commit), .scaning(scaning),
        .sc_sen(sc_sen), .dft_sout(dft_sout), .count(count)
    );

    dft_piso_scanout #(.WORD_W(W), .DEPTH(D), .CHAIN_LEN(CL2)) dut40 (
        .clk(clk), .reset(reset), .din(din2), .din_val(din_val2), .din_rdy(din_rdy2),
        .op(op2), .op_ack(op_ack2), .op_commit(op_commit2), .scaning(scaning2),
        .sc_sen(sc_sen2), .dft_sout(dft_sout2), .count(count2)
    );

    // Bit order in which a word appears on the chain, packed so that index 0 is the first bit.
    function automatic logic [W-1:0] ord(input logic [W-1:0] w);
        logic [W-1:0] r;
`ifdef DFT_PISO_MSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of words, plus a queue of bits still to be sent from the current word.
    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_DONE = 2;
    logic [W-1:0] m_fifo [$];
    bit           m_bits [$];
    int           m_phase = P_IDLE;
    int           m_left  = 0;
    bit           m_ack   = 0;

    always @(posedge clk) begin
        bit can_pop, can_push, nack;
        logic [W-1:0] w;
        if (reset) begin
            m_fifo.delete();
            m_bits.delete();
            m_phase = P_IDLE;
            m_left  = 0;
            m_ack   = 0;
        end else begin
            can_pop  = (m_fifo.size() != 0);
            can_push = din_val && (m_fifo.size() != D);
            nack     = 0;
            case (m_phase)
                P_IDLE: if (op) begin
                    m_phase = P_BUSY;
                    m_left  = CL;
                    nack    = 1;
                end
                P_BUSY: begin
                    if (m_bits.size() != 0) begin
                        void'(m_bits.pop_front());
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = P_DONE;
                            m_bits.delete();
                        end
                    end
                    if (m_phase == P_BUSY && m_bits.size() == 0 && can_pop) begin
                        w = m_fifo.pop_front();
                        for (int i = 0; i < W; i++) begin
`ifdef DFT_PISO_MSB_FIRST_EN
                            m_bits.push_back(w[W-1-i]);
`else
                            m_bits.push_back(w[i]);
`endif
                        end
                    end
                end
                default: m_phase = P_IDLE;
            endcase
            if (can_push) m_fifo.push_back(din);
            m_ack = nack;
        end
    end

    // Per-cycle compare of all outputs, sampled 1ns after the clock edge.
    always @(posedge clk) begin
        logic [CW+5:0] e, a;
        bit esen, ebit;
        #1;
        if (armed) begin
            esen = (m_phase == P_BUSY) && (m_bits.size() != 0);
            ebit = esen ? m_bits[0] : 1'b0;
            e = {m_ack, (m_phase == P_DONE), (m_phase == P_BUSY), esen, ebit,
                 (m_fifo.size() != D), CW'(m_fifo.size())};
            a = {op_ack, op_commit, scaning, sc_sen, dft_sout, din_rdy, count};
            n_vec++;
            if (a !== e) begin
                n_miss++;
                $display("FAIL model_cycle @%0t: dut %b model %b (ack,commit,scan,sen,sout,rdy,count)", $time, a, e);
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        din = w;
        din_val = 1'b1;
        @(negedge clk);
        din_val = 1'b0;
    endtask

    // Pulse op and observe the main DUT until op_commit (or until the budget runs out).
    task automatic watch(input int budget, output int ack_at, output int first_at, output int n_sen,
                         output int commit_at, output int gaps, output logic [63:0] cap);
        bit prev;
        ack_at = -1; first_at = -1; n_sen = 0; commit_at = -1; gaps = 0; cap = '0; prev = 0;
        op = 1'b1;
        @(negedge clk);
        op = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (op_ack && ack_at < 0) ack_at = k;
            if (sc_sen) begin
                if (first_at < 0) first_at = k;
                else if (!prev) gaps++;
                if (n_sen < 64) cap[n_sen] = dft_sout;
                n_sen++;
            end
            prev = sc_sen;
            if (op_commit) begin
                commit_at = k;
                break;
            end
            @(negedge clk);
        end
        if (commit_at < 0) check("watch_timeout", 0, 1);
    endtask

    task automatic feed_until_commit(input string name, input int budget);
        bit found;
        found = 0;
        for (int k = 0; k < budget; k++) begin
            din = $urandom;
            din_val = $urandom_range(0, 1) != 0;
            @(negedge clk);
            if (op_commit) begin
                found = 1;
                break;
            end
        end
        din_val = 1'b0;
        check(name, found, 1);
    endtask

    initial begin
        int ack_at, first_at, n_sen, commit_at, gaps, acks, commits;
        logic [63:0] cap;
        logic [W-1:0] o1, o2, w1, w2;
        bit seen;

        reset = 1'b1; din = '0; din_val = 1'b0; op = 1'b0;
        din2 = '0; din_val2 = 1'b0; op2 = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        armed = 1;
        check("rst_outputs", {op_ack, op_commit, scaning, sc_sen, dft_sout}, 0);
        check("rst_rdy", din_rdy, 1);
        check("rst_count", count, 0);
        reset = 1'b0;

        // Full 256-bit op from words 1..8.
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        check("t2_count8", count, 8);
        watch(400, ack_at, first_at, n_sen, commit_at, gaps, cap);
        o1 = ord(32'd1); o2 = ord(32'd2);
        check("t2_ack_at", ack_at, 1);
        check("t2_first_sen", first_at, 2);
        check("t2_nsen", n_sen, 256);
        check("t2_gaps", gaps, 0);
        check("t2_commit_at", commit_at, 258);
        check("t2_stream", cap, {o2, o1});
        check("t2_count0", count, 0);

        // Single word, then an underflow stall, then a late push.
        push_word(32'hA5A5A5A5);
        op = 1'b1;
        @(negedge clk);
        op = 1'b0;
        cap = '0; n_sen = 0;
        for (int k = 1; k <= 33; k++) begin
            if (sc_sen) begin
                if (n_sen < 64) cap[n_sen] = dft_sout;
                n_sen++;
            end
            @(negedge clk);
        end
        o1 = ord(32'hA5A5A5A5);
        check("t3_nbits", n_sen, 32);
        check("t3_word1", cap[31:0], o1);
        check("t3_stall", {scaning, sc_sen}, 2'b10);
        repeat (3) @(negedge clk);
        check("t3_stall_hold", {scaning, sc_sen}, 2'b10);
        din = 32'h0000FFFF;
        din_val = 1'b1;
        @(negedge clk);
        din_val = 1'b0;
        check("t3_sen_t1", sc_sen, 0);
        @(negedge clk);
        check("t3_sen_t2", sc_sen, 1);
        cap = '0; n_sen = 0;
        for (int k = 0; k < 32; k++) begin
            if (sc_sen) begin
                cap[n_sen] = dft_sout;
                n_sen++;
            end
            @(negedge clk);
        end
        o2 = ord(32'h0000FFFF);
        check("t3_nbits2", n_sen, 32);
        check("t3_word2", cap[31:0], o2);
        for (int i = 0; i < 6; i++) push_word($urandom);
        feed_until_commit("t3_commit", 300);

        // Overfill with nine words, then push and pop in the same cycle.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            din = $urandom;
            din_val = 1'b1;
            @(negedge clk);
            if (i == 7) begin
                check("t4_rdy_full", din_rdy, 0);
                check("t4_count_full", count, 8);
            end
        end
        din_val = 1'b0;
        check("t4_ninth_dropped", count, 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) push_word($urandom);
        op = 1'b1;
        @(negedge clk);
        op = 1'b0;
        check("t4_load_count", {scaning, sc_sen, 1'b0, count}, {2'b10, 1'b0, CW'(7)});
        din = $urandom;
        din_val = 1'b1;
        @(negedge clk);
        din_val = 1'b0;
        check("t4_pushpop_count", count, 7);
        feed_until_commit("t4_commit", 400);

        // Reset at bit 100 of an op aborts it.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) push_word($urandom);
        op = 1'b1;
        @(negedge clk);
        op = 1'b0;
        seen = 0; n_sen = 0;
        for (int k = 0; k < 300; k++) begin
            if (sc_sen) n_sen++;
            if (n_sen == 100) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("t5_reach100", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_abort", {sc_sen, scaning, op_commit, count}, 0);
        commits = 0;
        repeat (300) begin
            @(negedge clk);
            if (op_commit) commits++;
        end
        check("t5_no_commit", commits, 0);
        for (int i = 0; i < 8; i++) push_word($urandom);
        watch(400, ack_at, first_at, n_sen, commit_at, gaps, cap);
        check("t5_fresh_commit_at", commit_at, 258);
        check("t5_fresh_nsen", n_sen, 256);
        check("t5_fresh_gaps", gaps, 0);

        // CHAIN_LEN=40 instance; an op re-pulse during SHIFT is ignored.
        w1 = 32'hDEADBEEF; w2 = 32'h12345678;
        din2 = w1; din_val2 = 1'b1; @(negedge clk);
        din2 = w2; @(negedge clk);
        din2 = 32'hCAFEF00D; @(negedge clk);
        din_val2 = 1'b0;
        op2 = 1'b1;
        @(negedge clk);
        op2 = 1'b0;
        acks = 0; commits = 0; commit_at = -1; n_sen = 0; cap = '0;
        for (int k = 1; k <= 100; k++) begin
            if (op_ack2) acks++;
            if (sc_sen2) begin
                if (n_sen < 64) cap[n_sen] = dft_sout2;
                n_sen++;
            end
            if (op_commit2) begin
                commits++;
                commit_at = k;
            end
            op2 = (k == 10);
            @(negedge clk);
        end
        op2 = 1'b0;
        o1 = ord(w1); o2 = ord(w2);
        check("t6_acks", acks, 1);
        check("t6_commits", commits, 1);
        check("t6_commit_at", commit_at, 42);
        check("t6_nsen", n_sen, 40);
        check("t6_count_left", count2, 1);
        check("t6_stream", cap[39:0], {o2[7:0], o1});

        // Randomised traffic against the model, with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            din     = $urandom;
            din_val = $urandom_range(0, 3) != 0;
            op      = $urandom_range(0, 15) == 0;
            reset   = $urandom_range(0, 799) == 0;
            @(negedge clk);
        end
        reset = 1'b0; op = 1'b0; din_val = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
